// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: data width, FS opcodes,
// shifter mode encodings and the registered flag bundle.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_PASSA = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_NOTA  = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_DEC   = 4'd8;
    localparam logic [3:0] OP_SHL   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_ROL   = 4'd11;
    localparam logic [3:0] OP_INDAT = 4'd12;
    localparam logic [3:0] OP_INKBD = 4'd13;

    localparam logic [1:0] SHM_NONE = 2'd0;
    localparam logic [1:0] SHM_SHL  = 2'd1;
    localparam logic [1:0] SHM_SHR  = 2'd2;
    localparam logic [1:0] SHM_ROL  = 2'd3;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic n;
        logic d;
    } alu_flags_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate datapath: logical left, logical right and
// rotate left of A by SH, plus the bit that ends up in the carry flag.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [2:0]        SH,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] result,
    output logic              shifted_out
);

    logic [DATA_W:0]   shl_ext;
    logic [DATA_W:0]   shr_ext;
    logic [DATA_W-1:0] rol_val;

    always_comb begin
        // The extra guard bit catches the last bit shifted out; it is 0 when SH=0.
        shl_ext = {1'b0, A} << SH;
        shr_ext = {A, 1'b0} >> SH;
        rol_val = (A << SH) | (A >> (4'd8 - {1'b0, SH}));

        result      = A;
        shifted_out = 1'b0;
        case (mode)
            SHM_SHL: begin
                result      = shl_ext[DATA_W-1:0];
                shifted_out = shl_ext[DATA_W];
            end
            SHM_SHR: begin
                result      = shr_ext[DATA_W:1];
                shifted_out = shr_ext[0];
            end
            SHM_ROL: begin
                result      = rol_val;
                shifted_out = (SH != 3'd0) & rol_val[0];
            end
            default: begin
                result      = A;
                shifted_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit registered ALU: one combinational opcode decode feeding a single
// output register for FOut and the Z/C/V/N/D flags (latency 1 cycle).
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] OprdA,
    input  logic [DATA_W-1:0] OprdB,
    input  logic [DATA_W-1:0] InputPortData,
    input  logic [DATA_W-1:0] InputPortKeyBoard,
    input  logic [3:0]        FS,
    input  logic [2:0]        SH,
    output logic [DATA_W-1:0] FOut,
    output logic              Z,
    output logic              C,
    output logic              V,
    output logic              N,
    output logic              D
);

    logic [DATA_W-1:0] fout_d, fout_q;
    alu_flags_t        flags_d, flags_q;

    logic [1:0]        sh_mode;
    logic [DATA_W-1:0] sh_result;
    logic              sh_out;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   wide;
    logic [4:0]        nib;

    always_comb begin
        sh_mode = SHM_NONE;
        case (FS)
            OP_SHL:  sh_mode = SHM_SHL;
            OP_SHR:  sh_mode = SHM_SHR;
            OP_ROL:  sh_mode = SHM_ROL;
            default: sh_mode = SHM_NONE;
        endcase
    end

    // INC/DEC reuse the add/subtract paths with a constant second operand.
    always_comb begin
        b_op = OprdB;
        if (FS == OP_INC || FS == OP_DEC) begin
            b_op = 8'd1;
        end
    end

    alu_shifter u_shifter (
        .A           (OprdA),
        .SH          (SH),
        .mode        (sh_mode),
        .result      (sh_result),
        .shifted_out (sh_out)
    );

    always_comb begin
        fout_d  = '0;
        flags_d = '0;
        wide    = '0;
        nib     = '0;
        case (FS)
            OP_PASSA: fout_d = OprdA;
            OP_ADD, OP_INC: begin
                wide      = {1'b0, OprdA} + {1'b0, b_op};
                nib       = {1'b0, OprdA[3:0]} + {1'b0, b_op[3:0]};
                fout_d    = wide[DATA_W-1:0];
                flags_d.c = wide[DATA_W];
                flags_d.v = (OprdA[7] == b_op[7]) && (fout_d[7] != OprdA[7]);
                flags_d.d = nib[4];
            end
            OP_SUB, OP_DEC: begin
                // Bit 8 of the 9-bit difference is the unsigned borrow.
                wide      = {1'b0, OprdA} - {1'b0, b_op};
                nib       = {1'b0, OprdA[3:0]} - {1'b0, b_op[3:0]};
                fout_d    = wide[DATA_W-1:0];
                flags_d.c = wide[DATA_W];
                flags_d.v = (OprdA[7] != b_op[7]) && (fout_d[7] != OprdA[7]);
                flags_d.d = nib[4];
            end
            OP_AND:  fout_d = OprdA & OprdB;
            OP_OR:   fout_d = OprdA | OprdB;
            OP_XOR:  fout_d = OprdA ^ OprdB;
            OP_NOTA: fout_d = ~OprdA;
            OP_SHL, OP_SHR, OP_ROL: begin
                fout_d    = sh_result;
                flags_d.c = sh_out;
            end
            OP_INDAT: fout_d = InputPortData;
            OP_INKBD: fout_d = InputPortKeyBoard;
            default:  fout_d = '0;
        endcase
        flags_d.z = (fout_d == 8'h00);
        flags_d.n = fout_d[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fout_q  <= '0;
            flags_q <= '0;
        end else begin
            fout_q  <= fout_d;
            flags_q <= flags_d;
        end
    end

    assign FOut = fout_q;
    assign Z    = flags_q.z;
    assign C    = flags_q.c;
    assign V    = flags_q.v;
    assign N    = flags_q.n;
    assign D    = flags_q.d;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal vectors plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] a, b, dat, kbd;
    logic [3:0] fs;
    logic [2:0] sh;
    logic [7:0] fout;
    logic       z, c, v, n, d;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;
    logic [12:0] exp_q;

    alu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .OprdA             (a),
        .OprdB             (b),
        .InputPortData     (dat),
        .InputPortKeyBoard (kbd),
        .FS                (fs),
        .SH                (sh),
        .FOut              (fout),
        .Z                 (z),
        .C                 (c),
        .V                 (v),
        .N                 (n),
        .D                 (d)
    );

    always #5 clk = ~clk;

    // Result packed as {FOut, Z, C, V, N, D}.
    function automatic logic [12:0] model(input logic [3:0] f_s, input logic [7:0] aa,
                                          input logic [7:0] bb, input logic [7:0] pd,
                                          input logic [7:0] pk, input logic [2:0] s);
        int ai, bi, si, r, sa, sb, sr;
        logic cf, vf, df;
        logic [7:0] f;
        ai = int'(aa); bi = int'(bb); si = int'(s);
        cf = 1'b0; vf = 1'b0; df = 1'b0; r = 0;
        if (f_s == 4'd7 || f_s == 4'd8) bi = 1;
        sa = (ai > 127) ? ai - 256 : ai;
        sb = (bi > 127) ? bi - 256 : bi;
        case (f_s)
            4'd0: r = ai;
            4'd1, 4'd7: begin
                r = ai + bi; cf = (r > 255);
                sr = sa + sb; vf = (sr > 127) || (sr < -128);
                df = ((ai % 16) + (bi % 16)) > 15;
            end
            4'd2, 4'd8: begin
                r = ai - bi; cf = (ai < bi);
                sr = sa - sb; vf = (sr > 127) || (sr < -128);
                df = (ai % 16) < (bi % 16);
            end
            4'd3: r = ai & bi;
            4'd4: r = ai | bi;
            4'd5: r = ai ^ bi;
            4'd6: r = 255 - ai;
            4'd9: begin
                r = ai * (1 << si);
                cf = (si != 0) && (((ai >> (8 - si)) % 2) == 1);
            end
            4'd10: begin
                r = ai / (1 << si);
                cf = (si != 0) && (((ai >> (si - 1)) % 2) == 1);
            end
            4'd11: begin
                r = ((ai * (1 << si)) % 256) + ai / (1 << (8 - si));
                cf = (si != 0) && ((r % 2) == 1);
            end
            4'd12: r = int'(pd);
            4'd13: r = int'(pk);
            default: r = 0;
        endcase
        f = r[7:0];
        return {f, (f == 8'h00), cf, vf, f[7], df};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= '0;
        else        exp_q <= model(fs, a, b, dat, kbd, sh);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check("cycle", {19'd0, fout, z, c, v, n, d}, {19'd0, exp_q});
    end

    task automatic apply(input logic [3:0] f_s, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [2:0] s);
        @(negedge clk);
        #1;
        fs = f_s; a = aa; b = bb; sh = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] seq [14];
    logic [7:0] corner [4];

    initial begin
        a = 8'h00; b = 8'h00; dat = 8'h00; kbd = 8'h00; fs = 4'd0; sh = 3'd0;
        seq = '{8'h7A, 8'hCC, 8'h28, 8'h52, 8'h7A, 8'h28, 8'h85,
                8'h7B, 8'h79, 8'hA0, 8'h07, 8'hA7, 8'h3C, 8'hE1};
        corner = '{8'h00, 8'h7F, 8'h80, 8'hFF};

        // Reset behaviour before any clock edge and across edges.
        #1 rst_n = 1'b0;
        #1 check("rst_async", {fout, z, c, v, n, d}, 13'd0);
        a = 8'h7A; b = 8'h52; fs = 4'd1;
        repeat (2) @(posedge clk);
        #1 check("rst_hold", {fout, z, c, v, n, d}, 13'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("rst_release_hold", {fout, z, c, v, n, d}, 13'd0);
        @(posedge clk);
        #1 check("first_edge", {24'd0, fout}, 32'hCC);
        chk_en = 1'b1;

        // Reference vector A=7A B=52 SH=4 across all non-reserved opcodes.
        dat = 8'h3C; kbd = 8'hE1;
        for (int i = 0; i < 14; i++) begin
            apply(4'(i), 8'h7A, 8'h52, 3'd4);
            check($sformatf("seq_fs%0d", i), {24'd0, fout}, {24'd0, seq[i]});
            if (i == 1) check("add_flags", {28'd0, c, v, n, d}, {28'd0, 4'b0110});
            if (i == 2) check("sub_cv", {30'd0, c, v}, 32'd0);
            if (i >= 9 && i <= 11) check($sformatf("shift_c_fs%0d", i), {31'd0, c}, 32'd1);
        end

        apply(4'd7, 8'hFF, 8'h00, 3'd0);
        check("inc_ff", {fout, z, c, v, n, d}, {8'h00, 5'b11001});
        apply(4'd8, 8'h00, 8'h00, 3'd0);
        check("dec_00", {fout, z, c, v, n, d}, {8'hFF, 5'b01011});
        apply(4'd2, 8'h80, 8'h01, 3'd0);
        check("sub_80_01", {fout, z, c, v, n, d}, {8'h7F, 5'b00101});
        dat = 8'h00;
        apply(4'd12, 8'h55, 8'h00, 3'd0);
        check("indat_zero", {31'd0, z}, 32'd1);
        apply(4'd15, 8'hAA, 8'h55, 3'd3);
        check("reserved15", {fout, z, c, v, n, d}, {8'h00, 5'b10000});
        apply(4'd9, 8'h81, 8'h00, 3'd0);
        check("shl_sh0", {fout, z, c, v, n, d}, {8'h81, 5'b00010});
        apply(4'd11, 8'h81, 8'h00, 3'd1);
        check("rol_1", {24'd0, fout, c}, {24'd0, 8'h03, 1'b1});

        // FS change between edges: only the value present at the edge counts.
        @(negedge clk);
        #1 fs = 4'd1; a = 8'h7A; b = 8'h52;
        #2 fs = 4'd3;
        @(posedge clk);
        #1 check("fs_midcycle", {24'd0, fout}, 32'h52);

        // Mid-cycle reset while FOut=CC.
        apply(4'd1, 8'h7A, 8'h52, 3'd4);
        check("pre_rst_cc", {24'd0, fout}, 32'hCC);
        #1 rst_n = 1'b0;
        #1 check("mid_rst_clear", {fout, z, c, v, n, d}, 13'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 check("mid_rst_hold", {fout, z, c, v, n, d}, 13'd0);
        @(posedge clk);
        #1 check("mid_rst_resume", {24'd0, fout}, 32'hCC);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            #1;
            fs  = 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            sh  = 3'($urandom_range(0, 7));
            dat = 8'($urandom);
            kbd = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                #1 check("rand_rst", {fout, z, c, v, n, d}, 13'd0);
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
